// File: rtl/sumador_segmentado.sv
// ---------------------------------------------------------------------------
// sumador_segmentado
//
// Carry-segmented pipelined adder. Two WIDTH-bit unsigned operands are added
// one SW-bit slice per stage (SW = WIDTH/STAGES), the carry of each slice
// being registered and consumed by the next stage. A tag travels alongside
// the data and is incremented once per stage. Valid/ready handshaking on both
// sides; the whole pipeline advances together whenever the output register is
// empty or being consumed.
//
// Parameters
//   WIDTH   operand/sum width, multiple of STAGES
//   STAGES  number of pipeline stages (= adder slices), >= 1
//   IDX_W   tag width
//
// Ports
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset, clears every register
//   in_valid_i   operands and tag valid
//   in_ready_o   block accepts operands this cycle
//   in_idx_i     tag
//   in_a_i       operand A
//   in_b_i       operand B
//   out_valid_o  output holds a result
//   out_ready_i  consumer takes the result this cycle
//   out_idx_o    tag after the pipeline (in_idx + STAGES, wrapping)
//   out_sum_o    sum
//   out_carry_o  carry out of bit WIDTH-1
//
// Configuration
//   SUMADOR_SAT_EN  when defined, out_sum_o saturates to all ones whenever
//                   the final carry is set; out_carry_o still reports it.
// ---------------------------------------------------------------------------
module sumador_segmentado #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int IDX_W  = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [IDX_W-1:0] in_idx_i,
    input  logic [WIDTH-1:0] in_a_i,
    input  logic [WIDTH-1:0] in_b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [IDX_W-1:0] out_idx_o,
    output logic [WIDTH-1:0] out_sum_o,
    output logic             out_carry_o
);

    localparam int SW = WIDTH / STAGES;

    // Single advance enable for the whole pipeline: move when the last stage
    // is empty or its result is being taken, otherwise every register holds.
    logic en;
    assign en         = out_ready_i | ~out_valid_o;
    assign in_ready_o = en;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // RW: operand bits not yet added when entering stage k
        // LW: sum bits already computed when leaving stage k
        localparam int RW = WIDTH - k * SW;
        localparam int LW = (k + 1) * SW;

        logic [RW-1:0]    a_cur;
        logic [RW-1:0]    b_cur;
        logic             cin;
        logic             valid_d;
        logic [IDX_W-1:0] idx_src;
        logic [IDX_W-1:0] idx_d;
        logic [SW:0]      slice_w;
        logic [LW-1:0]    sum_d;

        logic             valid_q;
        logic [IDX_W-1:0] idx_q;
        logic [LW-1:0]    sum_q;
        logic             carry_q;

        // Stage 0 is fed from the ports with a zero carry-in; later stages
        // take the delayed upper operands, the lower partial sum and the
        // registered carry of the previous stage.
        if (k == 0) begin : g_head
            assign a_cur   = in_a_i;
            assign b_cur   = in_b_i;
            assign cin     = 1'b0;
            assign valid_d = in_valid_i;
            assign idx_src = in_idx_i;
            assign sum_d   = slice_w[SW-1:0];
        end else begin : g_body
            assign a_cur   = g_stage[k-1].g_fwd.a_q;
            assign b_cur   = g_stage[k-1].g_fwd.b_q;
            assign cin     = g_stage[k-1].carry_q;
            assign valid_d = g_stage[k-1].valid_q;
            assign idx_src = g_stage[k-1].idx_q;
            assign sum_d   = {slice_w[SW-1:0], g_stage[k-1].sum_q};
        end

        // The lowest SW bits of the remaining operands are this stage's slice.
        assign slice_w = {1'b0, a_cur[SW-1:0]} + {1'b0, b_cur[SW-1:0]}
                       + {{SW{1'b0}}, cin};
        assign idx_d   = idx_src + IDX_W'(1);

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                valid_q <= 1'b0;
                idx_q   <= '0;
                sum_q   <= '0;
                carry_q <= 1'b0;
            end else if (en) begin
                valid_q <= valid_d;
                idx_q   <= idx_d;
                sum_q   <= sum_d;
                carry_q <= slice_w[SW];
            end
        end

        // Upper operand slices still waiting for their stage; the last stage
        // has nothing left to delay.
        if (k < STAGES - 1) begin : g_fwd
            localparam int UW = RW - SW;

            logic [UW-1:0] a_q;
            logic [UW-1:0] b_q;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en) begin
                    a_q <= a_cur[RW-1:SW];
                    b_q <= b_cur[RW-1:SW];
                end
            end
        end
    end

    assign out_valid_o = g_stage[STAGES-1].valid_q;
    assign out_idx_o   = g_stage[STAGES-1].idx_q;
    assign out_carry_o = g_stage[STAGES-1].carry_q;

`ifdef SUMADOR_SAT_EN
    assign out_sum_o = g_stage[STAGES-1].carry_q ? '1 : g_stage[STAGES-1].sum_q;
`else
    assign out_sum_o = g_stage[STAGES-1].sum_q;
`endif

endmodule

// File: tb/tb_sumador_segmentado.sv
// ---------------------------------------------------------------------------
// tb_sumador_segmentado
//
// Bench for sumador_segmentado. Main instance WIDTH=8, STAGES=2, IDX_W=4 with
// a queue-based reference model; a second instance WIDTH=16, STAGES=4 checks
// the deeper pipeline latency.
// ---------------------------------------------------------------------------
module tb_sumador_segmentado;

    localparam int W  = 8;
    localparam int S  = 2;
    localparam int IW = 4;
    localparam int W2 = 16;
    localparam int S2 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstN;
    logic          inValid;
    logic          inReady;
    logic [IW-1:0] inIdx;
    logic [W-1:0]  inA;
    logic [W-1:0]  inB;
    logic          outValid;
    logic          outReady;
    logic [IW-1:0] outIdx;
    logic [W-1:0]  outSum;
    logic          outCarry;

    logic          in2Valid;
    logic          in2Ready;
    logic [IW-1:0] in2Idx;
    logic [W2-1:0] in2A;
    logic [W2-1:0] in2B;
    logic          out2Valid;
    logic          out2Ready;
    logic [IW-1:0] out2Idx;
    logic [W2-1:0] out2Sum;
    logic          out2Carry;

    sumador_segmentado #(.WIDTH(W), .STAGES(S), .IDX_W(IW)) dut (
        .clk_i       (clk),
        .rst_ni      (rstN),
        .in_valid_i  (inValid),
        .in_ready_o  (inReady),
        .in_idx_i    (inIdx),
        .in_a_i      (inA),
        .in_b_i      (inB),
        .out_valid_o (outValid),
        .out_ready_i (outReady),
        .out_idx_o   (outIdx),
        .out_sum_o   (outSum),
        .out_carry_o (outCarry)
    );

    sumador_segmentado #(.WIDTH(W2), .STAGES(S2), .IDX_W(IW)) dut2 (
        .clk_i       (clk),
        .rst_ni      (rstN),
        .in_valid_i  (in2Valid),
        .in_ready_o  (in2Ready),
        .in_idx_i    (in2Idx),
        .in_a_i      (in2A),
        .in_b_i      (in2B),
        .out_valid_o (out2Valid),
        .out_ready_i (out2Ready),
        .out_idx_o   (out2Idx),
        .out_sum_o   (out2Sum),
        .out_carry_o (out2Carry)
    );

    typedef struct packed {
        logic [W-1:0]  sum;
        logic          carry;
        logic [IW-1:0] idx;
    } exp_t;

    exp_t expQ[$];
    int   compareCount  = 0;
    int   mismatchCount = 0;
    int   outCount      = 0;

    // Every comparison funnels through here so the counters stay honest.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference: plain arithmetic on the full operands, tag advanced by the
    // pipeline depth, optional saturation on overflow.
    function automatic exp_t modelAdd(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic [IW-1:0] idx);
        exp_t        r;
        logic [W:0]  full;
        full    = {1'b0, a} + {1'b0, b};
        r.carry = full[W];
        r.sum   = full[W-1:0];
`ifdef SUMADOR_SAT_EN
        if (full[W]) r.sum = '1;
`endif
        r.idx   = idx + IW'(S);
        return r;
    endfunction

    // Called at a falling edge with inputs already driven: scores the
    // transfers that the next rising edge will perform, then moves on to the
    // following falling edge.
    task automatic stepCycle();
        exp_t e;
        #1;
        if (outValid && outReady) begin
            outCount++;
            if (expQ.size() == 0) begin
                checkOutput("spurious_out_valid", outValid, 1'b0);
            end else begin
                e = expQ.pop_front();
                checkOutput("sb_sum", outSum, e.sum);
                checkOutput("sb_carry", outCarry, e.carry);
                checkOutput("sb_idx", outIdx, e.idx);
            end
        end
        if (inValid && inReady) expQ.push_back(modelAdd(inA, inB, inIdx));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [IW-1:0] idx);
        inA     = a;
        inB     = b;
        inIdx   = idx;
        inValid = 1'b1;
    endtask

    // Single isolated transfer with the expected result spelled out.
    task automatic sendOne(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [IW-1:0] idx, input logic [W-1:0] expSum,
                           input logic expCarry, input logic [IW-1:0] expIdx);
        int lat;
        outReady = 1'b1;
        applyStimulus(a, b, idx);
        checkOutput("in_ready_idle", inReady, 1'b1);
        stepCycle();
        inValid = 1'b0;
        lat = 1;
        while (!outValid && lat < 20) begin
            stepCycle();
            lat++;
        end
        checkOutput("latency", lat, S);
        checkOutput("dir_sum", outSum, expSum);
        checkOutput("dir_carry", outCarry, expCarry);
        checkOutput("dir_idx", outIdx, expIdx);
        stepCycle();
    endtask

    task automatic sendWide(input logic [W2-1:0] a, input logic [W2-1:0] b,
                            input logic [IW-1:0] idx, input logic [W2-1:0] expSum,
                            input logic expCarry, input logic [IW-1:0] expIdx);
        int lat;
        in2A     = a;
        in2B     = b;
        in2Idx   = idx;
        in2Valid = 1'b1;
        #1;
        checkOutput("w_in_ready", in2Ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        in2Valid = 1'b0;
        lat = 1;
        while (!out2Valid && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        checkOutput("w_latency", lat, S2);
        checkOutput("w_sum", out2Sum, expSum);
        checkOutput("w_carry", out2Carry, expCarry);
        checkOutput("w_idx", out2Idx, expIdx);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input int expected, input string tag);
        int steps;
        inValid  = 1'b0;
        outReady = 1'b1;
        outCount = 0;
        steps    = 0;
        while (expQ.size() != 0 && steps < 50) begin
            stepCycle();
            steps++;
        end
        checkOutput({tag, "_left"}, expQ.size(), 0);
        if (expected >= 0) checkOutput({tag, "_count"}, outCount, expected);
    endtask

    // Watchdog in case some wait never completes.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [W-1:0] streamA [4];
    logic [W-1:0] streamB [4];
    logic [W-1:0] satVal;

    initial begin
        streamA = '{8'h01, 8'h03, 8'h80, 8'hAA};
        streamB = '{8'h02, 8'h04, 8'h80, 8'h55};

        rstN      = 1'b0;
        inValid   = 1'b0;
        inIdx     = '0;
        inA       = '0;
        inB       = '0;
        outReady  = 1'b1;
        in2Valid  = 1'b0;
        in2Idx    = '0;
        in2A      = '0;
        in2B      = '0;
        out2Ready = 1'b1;

        // Reset state.
        #12;
        checkOutput("rst_out_valid", outValid, 1'b0);
        checkOutput("rst_out_sum", outSum, 8'h00);
        checkOutput("rst_out_idx", outIdx, 4'h0);
        checkOutput("rst_out_carry", outCarry, 1'b0);
        checkOutput("rst_in_ready", inReady, 1'b1);
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_in_ready", inReady, 1'b1);

        // Carry propagating across the slice boundary.
        sendOne(8'h0F, 8'h01, 4'd3, 8'h10, 1'b0, 4'd5);

        // Overflow and tag wrap.
`ifdef SUMADOR_SAT_EN
        satVal = 8'hFF;
`else
        satVal = 8'h01;
`endif
        sendOne(8'hFF, 8'h02, 4'd15, satVal, 1'b1, 4'd1);

        // Back-to-back stream.
        outReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(streamA[i], streamB[i], 4'(i));
            stepCycle();
        end
        drain(S, "stream");

        // Backpressure with a full pipeline.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(8'(8'h10 * (i + 1)), 8'(8'h07 + i), 4'(8 + i));
            stepCycle();
        end
        outReady = 1'b0;
        applyStimulus(8'h11, 8'h22, 4'd12);
        for (int c = 0; c < 3; c++) begin
            #1;
            checkOutput("bp_in_ready", inReady, 1'b0);
            checkOutput("bp_out_valid", outValid, 1'b1);
            checkOutput("bp_hold_sum", outSum, expQ[0].sum);
            checkOutput("bp_hold_idx", outIdx, expQ[0].idx);
            stepCycle();
        end
        drain(2, "bp_drain");

        // Reset with two results in flight.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(8'(8'h21 + i), 8'h05, 4'(i));
            stepCycle();
        end
        inValid = 1'b0;
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("midrst_out_valid", outValid, 1'b0);
        checkOutput("midrst_out_sum", outSum, 8'h00);
        expQ.delete();
        @(negedge clk);
        rstN = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            checkOutput("no_stale_valid", outValid, 1'b0);
            stepCycle();
        end
        sendOne(8'h3C, 8'h41, 4'd7, 8'h7D, 1'b0, 4'd9);

        // Randomised traffic against the model.
        for (int c = 0; c < 400; c++) begin
            inValid  = 1'($urandom_range(0, 1));
            inA      = 8'($urandom);
            inB      = 8'($urandom);
            inIdx    = 4'($urandom);
            outReady = ($urandom_range(0, 3) != 0);
            stepCycle();
        end
        drain(-1, "rand_drain");

        // Deeper pipeline: WIDTH=16, STAGES=4.
        sendWide(16'h000F, 16'h0001, 4'd3, 16'h0010, 1'b0, 4'd7);
`ifdef SUMADOR_SAT_EN
        sendWide(16'hFFFF, 16'h0001, 4'd14, 16'hFFFF, 1'b1, 4'd2);
`else
        sendWide(16'hFFFF, 16'h0001, 4'd14, 16'h0000, 1'b1, 4'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
